// File: rtl/aes_ctr_stream_ctrl.sv
// CTR-mode streaming controller placed in front of a pipelined AES core.
// Accepted blocks are buffered while their counter blocks go to the core.
// Each result is the buffered block XOR the returned keystream, emitted in order.
module aes_ctr_stream_ctrl #(
    parameter int BLOCK_W     = 128,
    parameter int CTR_W       = 32,
    parameter int DEPTH       = 16,
    parameter int AES_LATENCY = 11,
    parameter int WRAP_STOP   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [BLOCK_W-1:0] nonce,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               aes_req_valid,
    output logic [BLOCK_W-1:0] aes_req_block,
    input  logic               aes_ks_valid,
    input  logic [BLOCK_W-1:0] aes_ks_block,
    output logic               busy,
    output logic               ctr_wrap,
    output logic               ks_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t             r_state;
    logic [BLOCK_W-1:0] r_ctr;
    logic [CW-1:0]      r_outst;
    logic [CW-1:0]      r_ks_cnt;
    logic [PW-1:0]      r_d_wp, r_d_rp, r_k_wp, r_k_rp;
    logic [BLOCK_W-1:0] r_d_mem [DEPTH];
    logic [BLOCK_W-1:0] r_k_mem [DEPTH];
    logic               r_req_valid;
    logic [BLOCK_W-1:0] r_req_block;
    logic               r_ctr_wrap;
    logic               r_ks_err;

    logic               w_acc, w_pop, w_d_pop, w_ks_push, w_ks_bad, w_wrap;
    logic [CW-1:0]      w_outst_nxt;

    // Handshakes; a data pop is also guarded so a stray keystream cannot underflow the data FIFO.
    assign in_ready  = (r_state == S_RUN) && (r_outst < CW'(DEPTH));
    assign out_valid = (r_ks_cnt != '0);
    assign w_acc     = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_d_pop   = w_pop && (r_outst != '0);
    assign w_ks_push = aes_ks_valid && (r_state != S_IDLE) && (r_ks_cnt != CW'(DEPTH));
    assign w_ks_bad  = aes_ks_valid && !w_ks_push;
    assign w_wrap    = w_acc && (&r_ctr[CTR_W-1:0]);

    // Output is forced to zero when nothing is valid so uninitialised buffer contents never leak.
    assign out_data      = out_valid ? (r_d_mem[r_d_rp] ^ r_k_mem[r_k_rp]) : '0;
    assign aes_req_valid = r_req_valid;
    assign aes_req_block = r_req_block;
    assign busy          = (r_state != S_IDLE);
    assign ctr_wrap      = r_ctr_wrap;
    assign ks_err        = r_ks_err;

    // Outstanding count after this cycle's accept and output handshake.
    always_comb begin
        w_outst_nxt = r_outst;
        case ({w_acc, w_d_pop})
            2'b10:   w_outst_nxt = r_outst + CW'(1);
            2'b01:   w_outst_nxt = r_outst - CW'(1);
            default: w_outst_nxt = r_outst;
        endcase
    end

    // Buffer storage: written on push only, contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (w_acc)     r_d_mem[r_d_wp] <= in_data;
        if (w_ks_push) r_k_mem[r_k_wp] <= aes_ks_block;
    end

    // Control FSM, counter, request register, FIFO pointers and sticky flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_ctr       <= '0;
            r_outst     <= '0;
            r_ks_cnt    <= '0;
            r_d_wp      <= '0;
            r_d_rp      <= '0;
            r_k_wp      <= '0;
            r_k_rp      <= '0;
            r_req_valid <= 1'b0;
            r_req_block <= '0;
            r_ctr_wrap  <= 1'b0;
            r_ks_err    <= 1'b0;
        end else begin
            r_req_valid <= w_acc;
            if (w_acc) begin
                r_req_block <= r_ctr;
                r_ctr       <= {r_ctr[BLOCK_W-1:CTR_W], r_ctr[CTR_W-1:0] + CTR_W'(1)};
                r_d_wp      <= r_d_wp + PW'(1);
            end
            if (w_d_pop)   r_d_rp <= r_d_rp + PW'(1);
            if (w_ks_push) r_k_wp <= r_k_wp + PW'(1);
            if (w_pop)     r_k_rp <= r_k_rp + PW'(1);
            case ({w_ks_push, w_pop})
                2'b10:   r_ks_cnt <= r_ks_cnt + CW'(1);
                2'b01:   r_ks_cnt <= r_ks_cnt - CW'(1);
                default: r_ks_cnt <= r_ks_cnt;
            endcase
            r_outst <= w_outst_nxt;
            if (w_wrap)   r_ctr_wrap <= 1'b1;
            if (w_ks_bad) r_ks_err   <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_ctr      <= nonce;
                        r_ctr_wrap <= 1'b0;
                        r_ks_err   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (stop || ((WRAP_STOP != 0) && w_wrap)) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_outst_nxt == '0) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_ctr_stream_ctrl.sv
// Directed bench for aes_ctr_stream_ctrl with an 11-cycle AES core model
// returning keystream = counter XOR A5..A5.
module tb_aes_ctr_stream_ctrl;
    localparam int BW = 128;
    localparam logic [BW-1:0] KS   = {16{8'hA5}};
    localparam logic [BW-1:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [BW-1:0] NW   = {96'h0123456789ABCDEF01234567, 32'hFFFFFFFE};
    localparam logic [BW-1:0] EXP1 = 128'hA5B48796E1F0C3D22D3C0F1E69784B5B;

    logic          clk = 1'b0;
    logic          reset, start, stop, in_valid, out_ready;
    logic [BW-1:0] nonce, in_data;
    logic          in_ready, out_valid, aes_req_valid, busy, ctr_wrap, ks_err;
    logic [BW-1:0] out_data, aes_req_block;
    logic          aes_ks_valid;
    logic [BW-1:0] aes_ks_block;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    aes_ctr_stream_ctrl #(.BLOCK_W(128), .CTR_W(32), .DEPTH(16), .AES_LATENCY(11), .WRAP_STOP(1)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .nonce(nonce),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .aes_req_valid(aes_req_valid), .aes_req_block(aes_req_block),
        .aes_ks_valid(aes_ks_valid), .aes_ks_block(aes_ks_block),
        .busy(busy), .ctr_wrap(ctr_wrap), .ks_err(ks_err)
    );

    // AES core model: fixed 11-cycle pipeline, not reset with the controller
    bit            m_v [11];
    logic [BW-1:0] m_b [11];
    always @(posedge clk) begin
        m_v[0] <= aes_req_valid;
        m_b[0] <= aes_req_block;
        for (int k = 1; k < 11; k++) begin
            m_v[k] <= m_v[k-1];
            m_b[k] <= m_b[k-1];
        end
    end
    assign aes_ks_valid = m_v[10];
    assign aes_ks_block = m_b[10] ^ KS;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ov(input int max, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < max) begin
            step();
            n++;
        end
        chk("wait_out_valid", out_valid, 1);
    endtask

    task automatic do_start(input logic [BW-1:0] nv);
        nonce = nv;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        chk("stop_idle_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, acc, seen;
        logic [BW-1:0] hold;
        reset = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        nonce = '0; in_data = '0;
        repeat (3) step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_req_valid", aes_req_valid, 0);
        chk("rst_req_block", aes_req_block, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {ctr_wrap, ks_err}, 0);
        reset = 1'b1;
        step();

        // Single block, latency and value
        do_start(128'h1);
        chk("run_busy", busy, 1);
        chk("run_in_ready", in_ready, 1);
        in_valid = 1'b1; in_data = PT;
        step();
        in_valid = 1'b0;
        chk("one_req_valid", aes_req_valid, 1);
        chk("one_req_block", aes_req_block, 128'h1);
        wait_ov(40, n);
        chk("one_latency", n, 12);
        chk("one_data", out_data, EXP1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("one_drained", out_valid, 0);
        do_stop();

        // Back-to-back 5 blocks
        do_start(128'h1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = PT + BW'(i);
            step();
            chk("b2b_req_valid", aes_req_valid, 1);
            chk("b2b_req_block", aes_req_block, BW'(i + 1));
        end
        in_valid = 1'b0;
        wait_ov(40, n);
        chk("b2b_latency", n, 8);
        for (int i = 0; i < 5; i++) begin
            chk("b2b_out_valid", out_valid, 1);
            chk("b2b_out_data", out_data, (PT + BW'(i)) ^ BW'(i + 1) ^ KS);
            step();
        end
        chk("b2b_empty", out_valid, 0);
        do_stop();

        // Backpressure: 20 offered, 16 accepted
        do_start(128'h1);
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = PT + BW'(acc);
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        chk("bp_accepted", acc, 16);
        chk("bp_in_ready", in_ready, 0);
        wait_ov(40, n);
        hold = out_data;
        repeat (25) step();
        chk("bp_stable", out_data, hold);
        chk("bp_head", out_data, PT ^ BW'(1) ^ KS);
        chk("bp_no_err", ks_err, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, (PT + BW'(i)) ^ BW'(i + 1) ^ KS);
            step();
        end
        chk("bp_empty", out_valid, 0);
        do_stop();

        // Counter wrap with WRAP_STOP=1
        do_start(NW);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = PT;
        chk("wr_ready0", in_ready, 1);
        step();
        chk("wr_req0", aes_req_block, NW);
        chk("wr_flag0", ctr_wrap, 0);
        in_data = PT + BW'(1);
        chk("wr_ready1", in_ready, 1);
        step();
        chk("wr_req1", aes_req_block, NW | BW'(1));
        chk("wr_flag1", ctr_wrap, 1);
        chk("wr_blocked", in_ready, 0);
        in_data = PT + BW'(2);
        step();
        step();
        chk("wr_blocked2", in_ready, 0);
        chk("wr_no_req", aes_req_valid, 0);
        chk("wr_draining", busy, 1);
        in_valid = 1'b0;
        wait_ov(40, n);
        chk("wr_out0", out_data, PT ^ NW ^ KS);
        step();
        chk("wr_out1_valid", out_valid, 1);
        chk("wr_out1", out_data, (PT + BW'(1)) ^ (NW | BW'(1)) ^ KS);
        step();
        chk("wr_idle", busy, 0);
        chk("wr_empty", out_valid, 0);

        // Stop after 3 blocks
        do_start(128'h1);
        chk("stop_flag_clr", ctr_wrap, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = PT + BW'(i);
            step();
        end
        in_valid = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        in_valid = 1'b1; in_data = PT + BW'(3);
        chk("stop_blocked", in_ready, 0);
        step();
        chk("stop_no_req", aes_req_valid, 0);
        in_valid = 1'b0;
        wait_ov(40, n);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("stop_out_data", out_data, (PT + BW'(i)) ^ BW'(i + 1) ^ KS);
            step();
        end
        chk("stop_last_data", out_data, (PT + BW'(2)) ^ BW'(3) ^ KS);
        chk("stop_busy_before", busy, 1);
        step();
        chk("stop_busy_after", busy, 0);
        chk("stop_empty", out_valid, 0);

        // Reset mid-stream with 4 blocks outstanding
        do_start(128'h1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = PT + BW'(i);
            step();
        end
        in_valid = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out_data", out_data, 0);
        chk("mrst_in_ready", in_ready, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_req_valid", aes_req_valid, 0);
        chk("mrst_ks_err0", ks_err, 0);
        seen = 0;
        repeat (20) begin
            step();
            if (out_valid) seen = 1;
        end
        chk("mrst_ks_err", ks_err, 1);
        chk("mrst_no_out", seen, 0);
        do_start(128'h1);
        chk("restart_err_clr", ks_err, 0);
        do_stop();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_ctr_stream_ctrl.md
Name: aes_ctr_stream_ctrl

Overview:
- Parametrised CTR-mode streaming controller that sits in front of an external pipelined AES core.
- Accepts plaintext (or ciphertext) blocks on a valid/ready stream and issues one counter block per accepted block to the core.
- Buffers data and returned keystream, then emits data XOR keystream on a backpressurable output stream.
- Adds what the single-block enable/valid_out flow lacks: backpressure, a credit-limited in-flight depth, a parametrised counter field with wrap detection, and a drain/stop mode.

Parameters:
- BLOCK_W, 128: block/data/counter width in bits.
- CTR_W, 32: width of the incrementing low counter field; bits [BLOCK_W-1:CTR_W] stay fixed at the nonce value.
- DEPTH, 16: max outstanding blocks (accepted, not yet output); power of two, >=2. Full throughput requires DEPTH >= AES_LATENCY+2.
- AES_LATENCY, 11: core request-to-keystream latency in cycles; used only by the bench and for throughput checks.
- WRAP_STOP, 1: 1 = on counter wrap, block further input and drain; 0 = flag the wrap and continue.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low; while low all state clears at the next rising clk.
- start  in  1  pulse; in IDLE, loads the counter from nonce and enters RUN.
- stop  in  1  pulse; in RUN, enters DRAIN.
- nonce  in  BLOCK_W  initial counter block, sampled on start.
- in_valid  in  1  input block valid.
- in_ready  out  1  controller can accept a block.
- in_data  in  BLOCK_W  plaintext/ciphertext block.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  BLOCK_W  in_data XOR keystream.
- aes_req_valid  out  1  counter block issued to the core (registered).
- aes_req_block  out  BLOCK_W  counter value (registered).
- aes_ks_valid  in  1  keystream returned; in order, one per request.
- aes_ks_block  in  BLOCK_W  keystream block.
- busy  out  1  state != IDLE.
- ctr_wrap  out  1  sticky; low CTR_W bits wrapped; cleared on start.
- ks_err  out  1  sticky; keystream arrived with no reserved slot or in IDLE; cleared on start.

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, counter 0, FIFOs empty, outstanding count 0.
- FSM states IDLE, RUN, DRAIN:
  - IDLE -> RUN on start; counter <= nonce; ctr_wrap and ks_err cleared.
  - RUN -> DRAIN on stop, or on wrap when WRAP_STOP=1.
  - DRAIN -> IDLE in the cycle outstanding reaches 0.
  - start is ignored outside IDLE; stop is ignored outside RUN. stop and wrap in the same cycle -> DRAIN.
- in_ready = (state==RUN) && (outstanding < DEPTH). It is combinational from registers only and never depends on in_valid.
- Accept (in_valid && in_ready) at cycle T:
  - in_data is pushed into the data FIFO (DEPTH entries).
  - Cycle T+1: aes_req_valid=1, aes_req_block = counter as it was at T.
  - Counter low CTR_W bits increment modulo 2^CTR_W; upper bits never change.
- Wrap: an accept while low bits are all ones sets ctr_wrap. That block still completes normally; with WRAP_STOP=1, in_ready is 0 from T+1.
- Keystream capture: on aes_ks_valid, aes_ks_block is pushed into the keystream FIFO (DEPTH entries). If the keystream FIFO is full or state==IDLE, set ks_err and discard the block.
- out_valid = keystream FIFO not empty. out_data = data FIFO head XOR keystream FIFO head. Both pop on out_valid && out_ready.
- out_valid and out_data hold stable while out_ready=0.
- Minimum latency from accept to out_valid is AES_LATENCY+2 cycles.
- outstanding: +1 on accept, -1 on output handshake; both in the same cycle -> unchanged. Bounded [0, DEPTH].
- Encrypt and decrypt are identical operations; there is no mode pin.
- Reset mid-operation discards all buffered blocks. The integrator resets the AES core with the same reset; any stale keystream arriving in IDLE sets ks_err only.

Test Plan:
- Bench core model returns keystream = counter XOR 128'hA5A5...A5 after 11 cycles. Reset, start with nonce=128'h1, send one block 128'h00112233445566778899aabbccddeeff -> aes_req_block=128'h1 at T+1; out_valid at T+13; out_data = pt XOR 128'hA5A5...A4.
- Back-to-back: 5 blocks pt+i, out_ready=1 -> counters 1..5 issued on consecutive cycles; 5 outputs on consecutive cycles, in order, each XORed with its own counter keystream.
- Backpressure: out_ready=0 while 20 blocks are offered -> exactly 16 accepted and in_ready=0 thereafter. out_data holds stable. Releasing out_ready drains 16 results in order with no loss.
- Wrap: nonce with low 32 bits = 32'hFFFFFFFE, WRAP_STOP=1, offer 4 blocks -> counters ...FFFFFFFE and ...FFFFFFFF accepted; ctr_wrap=1 after the second; in_ready=0; 2 outputs; state returns to IDLE, busy=0.
- stop: 3 blocks accepted, then stop -> no further accepts; 3 outputs emitted; IDLE reached the cycle the last output handshakes.
- Reset mid-stream: reset=0 for one cycle with 4 blocks outstanding -> all outputs 0 and FIFOs empty. Model keystream arriving afterwards sets ks_err and produces no out_valid.
